// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter interface checker.
// Holds the checker state encoding and the wrap +1 reference function.
package counter_pkg;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } chk_state_t;

    localparam int CNT_WIDTH = 4;

    // Successor of a width-bit counter value, wrapping MAX to 0.
    function automatic logic [31:0] next_cnt(
        input logic [31:0] prev,
        input int          width
    );
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (prev + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/counter_seq_checker_if.sv
// Observed-counter bundle plus checker status outputs.
// master drives the observed signals; slave is the checker side.
interface counter_seq_checker_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              en;
    logic              cnt_rst;
    logic [WIDTH-1:0]  cnt_in;
    logic              ovf_in;
    logic              err_clr;
    logic              locked;
    logic [WRAP_W-1:0] wrap_count;
    logic              err_seq;
    logic              err_ovf;
    logic [ERR_W-1:0]  err_count;
    logic              err_pulse;

    modport master (
        output en, cnt_rst, cnt_in, ovf_in, err_clr,
        input  locked, wrap_count, err_seq, err_ovf,
        input  err_count, err_pulse
    );

    modport slave (
        input  en, cnt_rst, cnt_in, ovf_in, err_clr,
        output locked, wrap_count, err_seq, err_ovf,
        output err_count, err_pulse
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/counter_seq_checker.sv
// In-system monitor for a free-running wrap counter and its overflow pulse.
// Checks strict +1 progression, overflow timing and tallies wraps/errors.
module counter_seq_checker
    import counter_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    counter_seq_checker_if.slave mon
);
    chk_state_t        r_state;
    logic [WIDTH-1:0]  r_prev;
    logic              r_locked;
    logic              r_err_seq;
    logic              r_err_ovf;
    logic              r_err_pulse;

    logic [WIDTH-1:0]  w_exp_cnt;
    logic              w_exp_ovf;
    logic              w_chk;
    logic              w_seq;
    logic              w_ovf;
    logic              w_err;
    logic              w_wrap;
    logic [WRAP_W-1:0] w_wrap_q;
    logic [ERR_W-1:0]  w_err_q;

    assign w_exp_cnt = WIDTH'(next_cnt(32'(r_prev), WIDTH));
    assign w_exp_ovf = (r_prev == {WIDTH{1'b1}});

    // Only a plain enabled sample in TRACK is compared.
    assign w_chk  = mon.en && !mon.err_clr && !mon.cnt_rst
                 && (r_state == TRACK);
    assign w_seq  = (mon.cnt_in != w_exp_cnt);
    assign w_ovf  = (mon.ovf_in != w_exp_ovf);
    assign w_err  = w_chk && (w_seq || w_ovf);
    assign w_wrap = w_chk && w_exp_ovf && mon.ovf_in
                 && (mon.cnt_in == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= UNSYNC;
            r_prev      <= '0;
            r_locked    <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_pulse <= 1'b0;
        end else if (mon.err_clr) begin
            r_state     <= UNSYNC;
            r_locked    <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_pulse <= 1'b0;
        end else if (mon.cnt_rst) begin
            r_state     <= TRACK;
            r_prev      <= '0;
            r_locked    <= 1'b1;
            r_err_pulse <= 1'b0;
        end else if (mon.en) begin
            r_prev <= mon.cnt_in;
            if (r_state == UNSYNC) begin
                r_state     <= TRACK;
                r_locked    <= 1'b1;
                r_err_pulse <= 1'b0;
            end else begin
                r_err_seq   <= r_err_seq | w_seq;
                r_err_ovf   <= r_err_ovf | w_ovf;
                r_err_pulse <= w_seq | w_ovf;
            end
        end else begin
            r_err_pulse <= 1'b0;
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (w_wrap),
        .q       (w_wrap_q)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mon.err_clr),
        .inc     (w_err),
        .q       (w_err_q)
    );

    assign mon.locked     = r_locked;
    assign mon.wrap_count = w_wrap_q;
    assign mon.err_seq    = r_err_seq;
    assign mon.err_ovf    = r_err_ovf;
    assign mon.err_count  = w_err_q;
    assign mon.err_pulse  = r_err_pulse;
endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed self-checking bench for counter_seq_checker.
// Scenario tasks run in sequence; each compares against hand-derived values.
module tb_counter_seq_checker;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    counter_seq_checker_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(4)) bus();

    counter_seq_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mon     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [3:0] c,
                        input logic o, input logic r,
                        input logic clr);
        @(negedge clk);
        bus.en      = e;
        bus.cnt_in  = c;
        bus.ovf_in  = o;
        bus.cnt_rst = r;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_locked got=%0b exp=0", bus.locked);
        end
        checks++;
        if (bus.wrap_count !== 8'd0 || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0",
                     bus.wrap_count, bus.err_count);
        end
        checks++;
        if ({bus.err_seq, bus.err_ovf, bus.err_pulse} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000",
                     {bus.err_seq, bus.err_ovf, bus.err_pulse});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_clean_run();
        for (int i = 0; i <= 32; i++) begin
            step(1'b1, 4'(i % 16), (i == 16 || i == 32), 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (bus.locked !== 1'b1) begin
                    failures++;
                    $display("FAIL clean_locked got=%0b exp=1", bus.locked);
                end
            end
        end
        checks++;
        if (bus.wrap_count !== 8'd2) begin
            failures++;
            $display("FAIL clean_wraps got=%0d exp=2", bus.wrap_count);
        end
        checks++;
        if ({bus.err_seq, bus.err_ovf} !== 2'b00 || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL clean_errs got=%b cnt=%0d exp=00 cnt=0",
                     {bus.err_seq, bus.err_ovf}, bus.err_count);
        end
    endtask

    task automatic test_skip();
        for (int v = 1; v <= 5; v++) step(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.err_seq, bus.err_ovf, bus.err_pulse} !== 3'b101) begin
            failures++;
            $display("FAIL skip_flags got=%b exp=101",
                     {bus.err_seq, bus.err_ovf, bus.err_pulse});
        end
        checks++;
        if (bus.err_count !== 4'd1) begin
            failures++;
            $display("FAIL skip_count got=%0d exp=1", bus.err_count);
        end
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.err_count !== 4'd1) begin
            failures++;
            $display("FAIL skip_resync got=%0b/%0d exp=0/1",
                     bus.err_pulse, bus.err_count);
        end
    endtask

    task automatic test_ovf_faults();
        step(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 4'd0 || bus.err_seq !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got=%0b/%0d/%0b exp=0/0/0",
                     bus.locked, bus.err_count, bus.err_seq);
        end
        for (int v = 9; v <= 15; v++) step(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.err_seq, bus.err_ovf, bus.err_pulse} !== 3'b011) begin
            failures++;
            $display("FAIL ovf_missing got=%b exp=011",
                     {bus.err_seq, bus.err_ovf, bus.err_pulse});
        end
        checks++;
        if (bus.wrap_count !== 8'd2) begin
            failures++;
            $display("FAIL ovf_nowrap got=%0d exp=2", bus.wrap_count);
        end
        for (int v = 1; v <= 3; v++) step(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.err_count !== 4'd2 || bus.err_seq !== 1'b0 || bus.err_pulse !== 1'b1) begin
            failures++;
            $display("FAIL ovf_spurious got=%0d/%0b/%0b exp=2/0/1",
                     bus.err_count, bus.err_seq, bus.err_pulse);
        end
    endtask

    task automatic test_cnt_rst();
        for (int v = 5; v <= 9; v++) step(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL rst_pulse got=%0b/%0b exp=1/0",
                     bus.locked, bus.err_pulse);
        end
        for (int v = 1; v <= 3; v++) begin
            step(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL rst_follow%0d got=%0b exp=0", v, bus.err_pulse);
            end
        end
        checks++;
        if (bus.err_count !== 4'd2 || bus.wrap_count !== 8'd2) begin
            failures++;
            $display("FAIL rst_counts got=%0d/%0d exp=2/2",
                     bus.err_count, bus.wrap_count);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 4'd0 || bus.err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_wins got=%0b/%0d/%0b exp=0/0/0",
                     bus.locked, bus.err_count, bus.err_ovf);
        end
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL clr_resync got=%0b/%0b exp=1/0",
                     bus.locked, bus.err_pulse);
        end
    endtask

    task automatic test_saturation();
        repeat (20) step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_count !== 4'd15 || bus.err_seq !== 1'b1) begin
            failures++;
            $display("FAIL sat_count got=%0d/%0b exp=15/1",
                     bus.err_count, bus.err_seq);
        end
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.locked, bus.err_seq, bus.err_ovf, bus.err_pulse} !== 4'b0000
            || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL sat_clear got=%b/%0d exp=0000/0",
                     {bus.locked, bus.err_seq, bus.err_ovf, bus.err_pulse},
                     bus.err_count);
        end
        checks++;
        if (bus.wrap_count !== 8'd2) begin
            failures++;
            $display("FAIL sat_wrapkeep got=%0d exp=2", bus.wrap_count);
        end
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL sat_relock got=%0b/%0d exp=1/0",
                     bus.locked, bus.err_count);
        end
    endtask

    task automatic test_enable_and_reset();
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'(11 - k), 1'(k % 2), 1'b0, 1'b0);
            checks++;
            if (bus.err_pulse !== 1'b0 || bus.err_count !== 4'd0) begin
                failures++;
                $display("FAIL en_hold%0d got=%0b/%0d exp=0/0",
                         k, bus.err_pulse, bus.err_count);
            end
        end
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL en_resume got=%0b/%0d exp=0/0",
                     bus.err_pulse, bus.err_count);
        end
        step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 4'd1) begin
            failures++;
            $display("FAIL en_jump got=%0b/%0d exp=1/1",
                     bus.err_pulse, bus.err_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.locked, bus.err_seq, bus.err_ovf, bus.err_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL async_flags got=%b exp=0000",
                     {bus.locked, bus.err_seq, bus.err_ovf, bus.err_pulse});
        end
        checks++;
        if (bus.wrap_count !== 8'd0 || bus.err_count !== 4'd0) begin
            failures++;
            $display("FAIL async_counts got=%0d/%0d exp=0/0",
                     bus.wrap_count, bus.err_count);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        bus.en      = 1'b0;
        bus.cnt_rst = 1'b0;
        bus.cnt_in  = 4'd0;
        bus.ovf_in  = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_clean_run();
        test_skip();
        test_ovf_faults();
        test_cnt_rst();
        test_back_to_back();
        test_saturation();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
